// File: rtl/vec_pkg.sv
// Shared types and constants for the vector writeback collector.
package vec_pkg;

  localparam int NB_LANES = 4;
  localparam int CHUNK_W  = 64;
  localparam int REGI_W   = 10;
  localparam int CNT_W    = 10;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic [CHUNK_W-1:0] data;
    logic [REGI_W-1:0]  off;
  } wb_entry_t;

endpackage

// File: rtl/vec_wb_fifo.sv
// Single-lane writeback FIFO; head is read combinationally, push lands on the next edge.
module vec_wb_fifo
  import vec_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so a full lane still accepts the push.
  assign do_push = push && (flush || !full || do_pop);
  assign wr_idx  = flush ? '0 : wr_ptr;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(do_push);
      count  <= CNT_W'(do_push);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/vec_wb_collector.sv
// Collects four ALU lane results into per-lane FIFOs and round-robins them onto
// the register-file write port, tracking per-instruction completion.
module vec_wb_collector
  import vec_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int FIFO_DEPTH = 2,
  parameter int CHUNK_W    = 64
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [9:0]         expected,
  input  logic               done0,
  input  logic               done1,
  input  logic               done2,
  input  logic               done3,
  input  logic [CHUNK_W-1:0] vd0,
  input  logic [CHUNK_W-1:0] vd1,
  input  logic [CHUNK_W-1:0] vd2,
  input  logic [CHUNK_W-1:0] vd3,
  input  logic [9:0]         regi0,
  input  logic [9:0]         regi1,
  input  logic [9:0]         regi2,
  input  logic [9:0]         regi3,
  output logic               lane_full0,
  output logic               lane_full1,
  output logic               lane_full2,
  output logic               lane_full3,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [CHUNK_W-1:0] wr_data,
  output logic [9:0]         wr_off,
  output logic [1:0]         wr_lane,
  output logic               busy,
  output logic               op_done,
  output logic               ovf_err
);

  if (CHUNK_W != vec_pkg::CHUNK_W || VLEN < CHUNK_W || VLEN > 1024 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("vec_wb_collector: unsupported parameter set");
  end

  logic [NB_LANES-1:0] done_v;
  logic [NB_LANES-1:0] full_v;
  logic [NB_LANES-1:0] empty_v;
  logic [NB_LANES-1:0] pop_v;
  wb_entry_t           din_v  [NB_LANES];
  wb_entry_t           head_v [NB_LANES];

  lane_t            rr_ptr;
  lane_t            grant;
  lane_t            idx;
  logic             hs;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] cnt_inc;

  assign done_v   = {done3, done2, done1, done0};
  assign din_v[0] = '{data: vd0, off: regi0};
  assign din_v[1] = '{data: vd1, off: regi1};
  assign din_v[2] = '{data: vd2, off: regi2};
  assign din_v[3] = '{data: vd3, off: regi3};

  assign {lane_full3, lane_full2, lane_full1, lane_full0} = full_v;

  for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
    vec_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .resetn(resetn),
      .flush (start),
      .push  (done_v[k]),
      .pop   (pop_v[k]),
      .din   (din_v[k]),
      .full  (full_v[k]),
      .empty (empty_v[k]),
      .head  (head_v[k])
    );
    assign pop_v[k] = hs && (grant == lane_t'(k));
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_valid = 1'b0;
    grant    = rr_ptr;
    idx      = rr_ptr;
    wr_data  = '0;
    wr_off   = '0;
    wr_lane  = '0;
    for (int i = 0; i < NB_LANES; i++) begin
      idx = rr_ptr + lane_t'(i);
      if (!wr_valid && !empty_v[idx]) begin
        wr_valid = 1'b1;
        grant    = idx;
      end
    end
    if (wr_valid) begin
      wr_data = head_v[grant].data;
      wr_off  = head_v[grant].off;
      wr_lane = grant;
    end
  end

  assign hs      = wr_valid && wr_ready;
  assign cnt_inc = (count == '1) ? count : count + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= grant + 1'b1;
    end
  end

  // A doneK that finds its lane full with no pop this cycle is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_err <= 1'b0;
    end else if (start) begin
      ovf_err <= 1'b0;
    end else if (|(done_v & full_v & ~pop_v)) begin
      ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy    <= 1'b0;
      op_done <= 1'b0;
      count   <= '0;
      exp_q   <= '0;
    end else begin
      op_done <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        count   <= '0;
        exp_q   <= expected;
        op_done <= (expected == '0);
      end else if (busy) begin
        if (exp_q == '0) begin
          busy <= 1'b0;
        end else if (hs) begin
          count <= cnt_inc;
          if (cnt_inc == exp_q) begin
            busy    <= 1'b0;
            op_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_wb_collector.sv
// Directed bench for vec_wb_collector: table-driven vectors plus hand sequences.
module tb_vec_wb_collector;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        wr_ready = 1'b0;
  logic [9:0]  expected = '0;
  logic [3:0]  done = '0;
  logic [63:0] vd [4];
  logic [9:0]  regi [4];
  logic        lf0, lf1, lf2, lf3;
  logic        wr_valid, busy, op_done, ovf_err;
  logic [63:0] wr_data;
  logic [9:0]  wr_off;
  logic [1:0]  wr_lane;
  logic [3:0]  lane_full;

  int checks = 0;
  int failures = 0;

  assign lane_full = {lf3, lf2, lf1, lf0};

  always #5 clk = ~clk;

  vec_wb_collector dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .expected  (expected),
    .done0     (done[0]),
    .done1     (done[1]),
    .done2     (done[2]),
    .done3     (done[3]),
    .vd0       (vd[0]),
    .vd1       (vd[1]),
    .vd2       (vd[2]),
    .vd3       (vd[3]),
    .regi0     (regi[0]),
    .regi1     (regi[1]),
    .regi2     (regi[2]),
    .regi3     (regi[3]),
    .lane_full0(lf0),
    .lane_full1(lf1),
    .lane_full2(lf2),
    .lane_full3(lf3),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_off    (wr_off),
    .wr_lane   (wr_lane),
    .busy      (busy),
    .op_done   (op_done),
    .ovf_err   (ovf_err)
  );

  typedef struct packed {
    logic       start;
    logic [9:0] exp_n;
    logic [3:0] done;
    logic [7:0] data;
    logic [9:0] off;
    logic       ready;
    logic       valid;
    logic [1:0] lane;
    logic [7:0] wdata;
    logic [9:0] woff;
    logic       busy;
    logic       op_done;
    logic       ovf;
    logic [3:0] full;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(logic s, logic [9:0] e, logic [3:0] d, logic [7:0] dat,
                              logic [9:0] o, logic r, logic val, logic [1:0] ln,
                              logic [7:0] wd, logic [9:0] wo, logic b, logic od,
                              logic ov, logic [3:0] f);
    return '{s, e, d, dat, o, r, val, ln, wd, wo, b, od, ov, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs set now are captured on the next rising edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      vd[k]   = '0;
      regi[k] = '0;
    end

    // start exp=2: lane 2 backpressure, full, overflow, push+pop while full
    tbl[0]  = mk(1, 2, 4'h0, 8'h00,   0, 0,  0, 0, 8'h00,   0, 1, 0, 0, 4'h0);
    tbl[1]  = mk(0, 0, 4'h4, 8'hAA,   0, 0,  1, 2, 8'hAA,   0, 1, 0, 0, 4'h0);
    tbl[2]  = mk(0, 0, 4'h4, 8'hBB,  64, 0,  1, 2, 8'hAA,   0, 1, 0, 0, 4'h4);
    tbl[3]  = mk(0, 0, 4'h4, 8'hCC, 128, 0,  1, 2, 8'hAA,   0, 1, 0, 1, 4'h4);
    tbl[4]  = mk(0, 0, 4'h0, 8'h00,   0, 0,  1, 2, 8'hAA,   0, 1, 0, 1, 4'h4);
    tbl[5]  = mk(0, 0, 4'h4, 8'hDD, 192, 1,  1, 2, 8'hBB,  64, 1, 0, 1, 4'h4);
    tbl[6]  = mk(0, 0, 4'h0, 8'h00,   0, 1,  1, 2, 8'hDD, 192, 0, 1, 1, 4'h0);
    tbl[7]  = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 0, 0, 1, 4'h0);
    // rr_ptr=3: lanes 0 and 3 pending -> 3 first, then 0 (not busy, no count)
    tbl[8]  = mk(0, 0, 4'h9, 8'h5A,  10, 0,  1, 3, 8'h5A,  10, 0, 0, 1, 4'h0);
    tbl[9]  = mk(0, 0, 4'h0, 8'h00,   0, 1,  1, 0, 8'h5A,  10, 0, 0, 1, 4'h0);
    tbl[10] = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 0, 0, 1, 4'h0);
    // expected=0: busy and op_done for exactly one cycle, ovf cleared
    tbl[11] = mk(1, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 1, 1, 0, 4'h0);
    tbl[12] = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 0, 0, 0, 4'h0);
    tbl[13] = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 0, 0, 0, 4'h0);
    // expected=8 aborted after 3 writes by start with expected=2
    tbl[14] = mk(1, 8, 4'h7, 8'h11,  20, 1,  1, 1, 8'h11,  20, 1, 0, 0, 4'h0);
    tbl[15] = mk(0, 0, 4'h0, 8'h00,   0, 1,  1, 2, 8'h11,  20, 1, 0, 0, 4'h0);
    tbl[16] = mk(0, 0, 4'h0, 8'h00,   0, 1,  1, 0, 8'h11,  20, 1, 0, 0, 4'h0);
    tbl[17] = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 1, 0, 0, 4'h0);
    tbl[18] = mk(1, 2, 4'hC, 8'h22,  30, 1,  1, 2, 8'h22,  30, 1, 0, 0, 4'h0);
    tbl[19] = mk(0, 0, 4'h0, 8'h00,   0, 1,  1, 3, 8'h22,  30, 1, 0, 0, 4'h0);
    tbl[20] = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 0, 1, 0, 4'h0);
    tbl[21] = mk(0, 0, 4'h0, 8'h00,   0, 1,  0, 0, 8'h00,   0, 0, 0, 0, 4'h0);

    // Reset state
    cyc();
    cyc();
    check("rst.wr_valid", 64'(wr_valid), 0);
    check("rst.busy", 64'(busy), 0);
    check("rst.op_done", 64'(op_done), 0);
    check("rst.ovf_err", 64'(ovf_err), 0);
    check("rst.lane_full", 64'(lane_full), 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.wr_off", 64'(wr_off), 0);
    check("rst.wr_lane", 64'(wr_lane), 0);
    resetn = 1'b1;
    cyc();

    // Four lanes complete together: written in lane order 0..3 on consecutive cycles
    start = 1'b1;
    expected = 10'd4;
    done = 4'hF;
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vd[k]   = 64'(k + 1);
      regi[k] = 10'(64 * k);
    end
    cyc();
    start = 1'b0;
    done = 4'h0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1.w%0d.valid", k), 64'(wr_valid), 1);
      check($sformatf("t1.w%0d.lane", k), 64'(wr_lane), 64'(k));
      check($sformatf("t1.w%0d.data", k), wr_data, 64'(k + 1));
      check($sformatf("t1.w%0d.off", k), 64'(wr_off), 64'(64 * k));
      check($sformatf("t1.w%0d.busy", k), 64'(busy), 1);
      check($sformatf("t1.w%0d.op_done", k), 64'(op_done), 0);
      cyc();
    end
    check("t1.end.op_done", 64'(op_done), 1);
    check("t1.end.busy", 64'(busy), 0);
    check("t1.end.wr_valid", 64'(wr_valid), 0);
    cyc();
    check("t1.after.op_done", 64'(op_done), 0);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      start    = tbl[i].start;
      expected = tbl[i].exp_n;
      done     = tbl[i].done;
      wr_ready = tbl[i].ready;
      for (int k = 0; k < 4; k++) begin
        vd[k]   = {56'b0, tbl[i].data};
        regi[k] = tbl[i].off;
      end
      cyc();
      check($sformatf("v%0d.wr_valid", i), 64'(wr_valid), 64'(tbl[i].valid));
      check($sformatf("v%0d.busy", i), 64'(busy), 64'(tbl[i].busy));
      check($sformatf("v%0d.op_done", i), 64'(op_done), 64'(tbl[i].op_done));
      check($sformatf("v%0d.ovf_err", i), 64'(ovf_err), 64'(tbl[i].ovf));
      check($sformatf("v%0d.lane_full", i), 64'(lane_full), 64'(tbl[i].full));
      if (tbl[i].valid) begin
        check($sformatf("v%0d.wr_lane", i), 64'(wr_lane), 64'(tbl[i].lane));
        check($sformatf("v%0d.wr_data", i), wr_data, {56'b0, tbl[i].wdata});
        check($sformatf("v%0d.wr_off", i), 64'(wr_off), 64'(tbl[i].woff));
      end
    end

    // Asynchronous reset with three entries queued and an instruction in flight
    start = 1'b1;
    expected = 10'd5;
    done = 4'h3;
    wr_ready = 1'b0;
    cyc();
    start = 1'b0;
    done = 4'h1;
    cyc();
    done = 4'h0;
    check("ar.pre.busy", 64'(busy), 1);
    check("ar.pre.wr_valid", 64'(wr_valid), 1);
    check("ar.pre.lane_full", 64'(lane_full), 64'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar.wr_valid", 64'(wr_valid), 0);
    check("ar.busy", 64'(busy), 0);
    check("ar.lane_full", 64'(lane_full), 0);
    check("ar.wr_data", wr_data, 0);
    cyc();
    resetn = 1'b1;
    wr_ready = 1'b1;
    cyc();
    check("ar.post.wr_valid", 64'(wr_valid), 0);
    check("ar.post.busy", 64'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_wb_collector.md
Name: vec_wb_collector

Overview:
- Downstream writeback stage of the four-lane vector ALU wrapper.
- Captures each lane's completion (64-bit result chunk plus bit offset) into a small per-lane FIFO.
- Round-robin arbitrates the four lanes onto the single vector-register-file write port, with ready/valid flow control.
- Counts committed chunks against an expected total per vector instruction and signals instruction completion, lane backpressure and overflow errors.

Parameters:
- VLEN, 10'd128, vector register length in bits; wr_off range is 0..VLEN-1.
- FIFO_DEPTH, 2, entries per lane FIFO; power of two, minimum 2.
- CHUNK_W, 64, result chunk width in bits; equals ALU lane output width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse at vector instruction issue.
- expected  in  10  number of chunks the instruction will write; sampled on start.
- done0..done3  in  1 each  lane completion strobe, one cycle per chunk.
- vd0..vd3  in  CHUNK_W each  lane result; valid only with its done.
- regi0..regi3  in  10 each  lane destination bit offset; valid only with its done.
- lane_full0..lane_full3  out  1 each  lane FIFO full; the ALU must not raise done while its lane_full is high.
- wr_valid  out  1  write request to the register file.
- wr_ready  in  1  register file accepts the write this cycle.
- wr_data  out  CHUNK_W  chunk to write.
- wr_off  out  10  destination bit offset.
- wr_lane  out  2  source lane of the current request (debug/trace).
- busy  out  1  instruction in flight.
- op_done  out  1  one-cycle completion pulse.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset:
  - All FIFOs empty; round-robin pointer = 0; commit count = 0.
  - busy, op_done, ovf_err, wr_valid, lane_full* = 0.
  - wr_data, wr_off, wr_lane = 0.
- Capture:
  - When doneK=1 and lane K FIFO is not full, push {vdK, regiK}.
  - Storage is registered. done at edge N makes the entry visible as wr_valid after edge N (same-cycle bypass is not permitted).
  - Push and pop on the same lane in the same cycle is legal even when full: the pop frees the slot and the push is accepted.
- Overflow:
  - doneK=1 while lane K is full and not popped that cycle: the data is dropped and ovf_err is set.
  - ovf_err holds until the next start or reset.
- Arbitration:
  - Candidates are lanes with a non-empty FIFO.
  - Search order begins at rr_ptr: rr_ptr, rr_ptr+1, ... mod 4. The first candidate in that order drives wr_data, wr_off and wr_lane from its FIFO head.
  - wr_valid = at least one candidate. Outputs are combinational from the FIFO heads.
  - Handshake occurs when wr_valid && wr_ready: pop the granted FIFO; rr_ptr <= granted+1 mod 4.
  - Without a handshake, rr_ptr holds. A pending request stays stable on the granted lane unless a lower-order-position lane becomes non-empty; that is permitted, since the grant is re-evaluated every cycle.
- Commit counting:
  - start=1: busy <= 1, count <= 0, latch expected, clear ovf_err, flush all FIFOs. Any doneK in the start cycle is still captured after the flush (issue pipelining).
  - Each handshake while busy: count += 1.
  - When the incremented count equals the latched expected: op_done pulses for one cycle on the next edge, and busy <= 0 on the same edge.
  - expected=0: op_done pulses in the cycle after start; busy rises for exactly one cycle.
  - start while busy aborts the current instruction: no op_done for it, and the counter restarts.
  - Handshakes while not busy still pop data but do not count.
  - Count saturates at 1023; this is never reached in legal use.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); the FIFO contents are lost.

Decomposition:
- Shared package vec_pkg:
  - NB_LANES=4, CHUNK_W=64, REGI_W=10.
  - Typedef of the wb entry struct {data, off}.
  - Lane-index typedef (2 bits).
- Sub-module vec_wb_fifo: a single-lane synchronous FIFO (push, pop, full, empty, head) instantiated four times.
- The round-robin select stays inline in the top module.

Test Plan:
- Reset, then start with expected=4; done0..3 together with vdK=K+1, regiK=64K; wr_ready=1 → four writes on consecutive cycles, lane order 0,1,2,3; op_done one cycle after the 4th write; busy falls on the same edge.
- wr_ready=0 for 5 cycles while lane 2 gets done with vd=0xAA, regi=0 then vd=0xBB, regi=64 → lane_full2=1 after the second push; a third done2 sets ovf_err. Release wr_ready → 0xAA then 0xBB written; ovf_err stays 1 until the next start.
- rr_ptr=3 (previous grant lane 2); lanes 0 and 3 both pending → lane 3 granted first, then lane 0.
- start with expected=0 → op_done pulse the next cycle; busy high exactly one cycle; no writes.
- expected=8, abort after 3 writes with start, expected=2 → no op_done for the first instruction; op_done after 2 further writes.
- Assert resetn low with 3 entries queued and busy=1 → wr_valid, busy and lane_full* drop to 0 immediately, with no clock edge required.
